// File: rtl/sram_linebuf_controller.sv
// sram_linebuf_controller: line-buffer SRAM address/enable sequencer for a KxK window; define WIN_COUNT_EN to add a per-frame win_count output
module sram_linebuf_controller #(
  parameter int KER_SIZE    = 3,
  parameter int INPUT_X_DIM = 28,
  parameter int INPUT_Y_DIM = 28,
  parameter int ROW_STRIDE  = 1,
  parameter int COL_STRIDE  = 1,
  parameter int AW          = 5,
  parameter int YW          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              out_ready,
  output logic [AW-1:0]     addr,
  output logic [KER_SIZE:0] write_en,
  output logic [KER_SIZE:0] read_en,
  output logic              win_valid,
  output logic [YW-1:0]     win_row,
  output logic [AW-1:0]     win_col,
  output logic              row_is_complete,
  output logic              frame_done
`ifdef WIN_COUNT_EN
  ,
  output logic [15:0]       win_count
`endif
);
  localparam int NB = KER_SIZE + 1;
  localparam int RW = $clog2(NB);
  localparam logic [AW-1:0] X_LAST = AW'(INPUT_X_DIM - 1);
  localparam logic [AW-1:0] K_LAST = AW'(KER_SIZE - 1);
  localparam logic [RW-1:0] R_LAST = RW'(KER_SIZE);
  localparam logic [YW-1:0] Y_FILL = YW'(KER_SIZE - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(INPUT_Y_DIM - 1);
  localparam logic [2:0] CS_LAST = 3'(COL_STRIDE - 1);
  localparam logic [2:0] RS_LAST = 3'(ROW_STRIDE - 1);
  typedef enum logic [1:0] {FILL, STREAM, DRAIN} state_t;
  state_t state, state_n;
  logic [AW-1:0] col_ptr, col_n;
  logic [RW-1:0] row_ptr, row_n;
  logic [YW-1:0] y_ptr, y_n;
  logic [2:0] col_phase, cp_n, row_phase, rp_n;
  logic cand, accept, adv, row_end;
  always_comb begin
    cand = state != FILL && col_ptr >= K_LAST && col_phase == '0 && row_phase == '0;
    in_ready = state != DRAIN && (!cand || out_ready);
    accept = in_valid && in_ready;
    win_valid = cand && (state == DRAIN || in_valid);
    adv = state == DRAIN ? (!cand || out_ready) : accept;
    row_end = adv && col_ptr == X_LAST;
    write_en = accept ? NB'(1) << row_ptr : '0;
    read_en = adv && state != FILL ? ~(NB'(1) << row_ptr) : '0;
    row_is_complete = accept && col_ptr == X_LAST;
    frame_done = row_end && state == DRAIN && !flush;
  end
  assign addr = col_ptr;
  assign win_col = col_ptr;
  assign win_row = y_ptr - YW'(KER_SIZE);
  always_comb begin
    state_n = state;
    col_n = col_ptr;
    row_n = row_ptr;
    y_n = y_ptr;
    cp_n = col_phase;
    rp_n = row_phase;
    if (adv) begin
      col_n = row_end ? '0 : col_ptr + 1'b1;
      if (col_ptr >= K_LAST) cp_n = col_phase == CS_LAST ? '0 : col_phase + 1'b1;
      if (row_end) begin
        cp_n = '0;
        row_n = row_ptr == R_LAST ? '0 : row_ptr + 1'b1;
        y_n = y_ptr + 1'b1;
        rp_n = state == FILL ? '0 : (row_phase == RS_LAST ? '0 : row_phase + 1'b1);
        if (state == FILL && y_ptr == Y_FILL) state_n = STREAM;
        if (state == STREAM && y_ptr == Y_LAST) state_n = DRAIN;
        if (state == DRAIN) begin
          state_n = FILL;
          row_n = '0;
          y_n = '0;
          rp_n = '0;
        end
      end
    end
    // flush wins over any accept or advance in the same cycle
    if (flush) begin
      state_n = FILL;
      col_n = '0;
      row_n = '0;
      y_n = '0;
      cp_n = '0;
      rp_n = '0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= FILL;
      col_ptr <= '0;
      row_ptr <= '0;
      y_ptr <= '0;
      col_phase <= '0;
      row_phase <= '0;
    end else begin
      state <= state_n;
      col_ptr <= col_n;
      row_ptr <= row_n;
      y_ptr <= y_n;
      col_phase <= cp_n;
      row_phase <= rp_n;
    end
`ifdef WIN_COUNT_EN
  logic [15:0] cnt;
  logic xfer;
  assign xfer = win_valid && out_ready;
  // the last drain column may itself transfer a window, so include it in the snapshot
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      win_count <= '0;
    end else if (flush) begin
      cnt <= '0;
    end else if (frame_done) begin
      win_count <= cnt + 16'(xfer);
      cnt <= '0;
    end else if (xfer) begin
      cnt <= cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_sram_linebuf_controller.sv
// tb_sram_linebuf_controller: stride-1 and stride-2 controllers driven by shared random stimulus, checked against a pixel-count model and window scoreboard
module tb_sram_linebuf_controller;
  localparam int K = 3, X = 6, Y = 5, AW = 3, YW = 3;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  int n_cmp = 0, n_fail = 0;
  always #5 clk = ~clk;

  task automatic chk(input int g, input string n, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL dut%0d %s: got %0d, expected %0d at %0t", g, n, act, exp, $time);
    end
  endtask

  task automatic drive(input bit v, input bit r, input bit f);
    @(posedge clk);
    #1;
    in_valid = v;
    out_ready = r;
    flush = f;
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int S = g + 1;
    localparam int NWIN = ((X - K + S) / S) * ((Y - K + S) / S);
    logic in_ready, win_valid, row_is_complete, frame_done;
    logic [AW-1:0] addr, win_col;
    logic [K:0] write_en, read_en;
    logic [YW-1:0] win_row;
`ifdef WIN_COUNT_EN
    logic [15:0] win_count;
    int exp_wc = 0;
`endif
    int p = 0, d = 0, exp_frames = 0, dut_frames = 0, wins = 0;
    int qr[$], qc[$];

    sram_linebuf_controller #(
      .KER_SIZE(K), .INPUT_X_DIM(X), .INPUT_Y_DIM(Y),
      .ROW_STRIDE(S), .COL_STRIDE(S), .AW(AW), .YW(YW)
    ) dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .out_ready(out_ready), .addr(addr), .write_en(write_en), .read_en(read_en),
      .win_valid(win_valid), .win_row(win_row), .win_col(win_col),
      .row_is_complete(row_is_complete), .frame_done(frame_done)
`ifdef WIN_COUNT_EN
      , .win_count(win_count)
`endif
    );

    // model: p pixels of this frame accepted so far, d drain columns advanced
    initial forever begin : model
      int r, c, bank, exp_re;
      bit drn, here, rdy, acc, wv, adv;
      @(negedge clk);
      if (rst) begin
        p = 0;
        d = 0;
        qr.delete();
        qc.delete();
`ifdef WIN_COUNT_EN
        exp_wc = 0;
`endif
      end
      drn = p == X * Y;
      r = drn ? Y : p / X;
      c = drn ? d : p % X;
      bank = r % (K + 1);
      here = r >= K && c >= K - 1 && (c - K + 1) % S == 0 && (r - K) % S == 0;
      rdy = !drn && (!here || out_ready);
      acc = in_valid && rdy;
      wv = here && (drn || in_valid);
      adv = drn ? (!here || out_ready) : acc;
      exp_re = (adv && r >= K) ? ((1 << (K + 1)) - 1) & ~(1 << bank) : 0;
      if (flush && !rst) begin
        p = 0;
        d = 0;
        qr.delete();
        qc.delete();
      end else begin
        chk(g, "in_ready", in_ready, rdy);
        chk(g, "win_valid", win_valid, wv);
        chk(g, "write_en", write_en, acc ? 1 << bank : 0);
        chk(g, "read_en", read_en, exp_re);
        chk(g, "addr", addr, c);
        chk(g, "row_is_complete", row_is_complete, acc && c == X - 1);
        chk(g, "frame_done", frame_done, drn && adv && c == X - 1);
        if (wv) chk(g, "win_row", win_row, r - K);
`ifdef WIN_COUNT_EN
        chk(g, "win_count", win_count, exp_wc);
`endif
        if (!rst) begin
          if (wv && out_ready) begin
            qr.push_back(r - K);
            qc.push_back(c);
          end
          if (acc) p++;
          if (drn && adv) begin
            d++;
            if (d == X) begin
              p = 0;
              d = 0;
              exp_frames++;
`ifdef WIN_COUNT_EN
              exp_wc = NWIN;
`endif
            end
          end
        end
      end
    end

    initial forever begin : monitor
      @(negedge clk);
      #1;
      if (rst || flush) begin
        wins = 0;
      end else begin
        if (win_valid && out_ready) begin
          chk(g, "sb_has_entry", qr.size() > 0, 1);
          if (qr.size() > 0) begin
            chk(g, "sb_win_row", win_row, qr.pop_front());
            chk(g, "sb_win_col", win_col, qc.pop_front());
          end
          wins++;
        end
        if (frame_done) begin
          chk(g, "wins_per_frame", wins, NWIN);
          wins = 0;
          dut_frames++;
        end
      end
    end
  end

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    repeat (80) drive(1, 1, 0);
    for (int i = 0; i < 100 && g_inst[0].p != 3 * X + 4; i++) drive(1, 1, 0);
    chk(0, "reach_row3_col4", g_inst[0].p, 3 * X + 4);
    flush = 1;
    drive(1, 1, 0);
    chk(0, "flush_addr", g_inst[0].addr, 0);
    chk(0, "flush_pixels", g_inst[0].p, 0);
    for (int i = 0; i < 150; i++) drive(1, i % 7 >= 3, 0);
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 299) == 0);
    for (int i = 0; i < 200 && g_inst[0].p != X * Y; i++) drive(1, 1, 0);
    chk(0, "reach_drain", g_inst[0].p, X * Y);
    @(posedge clk);
    #3;
    rst = 1;
    in_valid = 0;
    #1;
    chk(0, "rst_in_ready", g_inst[0].in_ready, 1);
    chk(0, "rst_win_valid", g_inst[0].win_valid, 0);
    chk(0, "rst_write_en", g_inst[0].write_en, 0);
    chk(0, "rst_read_en", g_inst[0].read_en, 0);
    chk(0, "rst_addr", g_inst[0].addr, 0);
    chk(0, "rst_frame_done", g_inst[0].frame_done, 0);
    chk(1, "rst_in_ready", g_inst[1].in_ready, 1);
    chk(1, "rst_addr", g_inst[1].addr, 0);
    @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 300; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0, 0);
    repeat (120) drive(1, 1, 0);
    chk(0, "frames", g_inst[0].dut_frames, g_inst[0].exp_frames);
    chk(1, "frames", g_inst[1].dut_frames, g_inst[1].exp_frames);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/sram_linebuf_controller.md
Name: sram_linebuf_controller

Overview:
Address and enable generator for a (KER_SIZE+1)-row SRAM line buffer feeding a KxK convolution window. It supports independent row and column strides, valid/ready handshaking on both input and window output, and full-frame sequencing. At the end of each frame it runs an internal drain row, so the last window row is emitted without extra input. It sits between the pixel stream and the line-buffer SRAM banks/window shift register in each conv layer.

Parameters:
KER_SIZE, 3, kernel height/width K; the buffer has K+1 rows.
INPUT_X_DIM, 28, pixels per row (X).
INPUT_Y_DIM, 28, rows per frame (Y); must satisfy Y >= K.
ROW_STRIDE, 1, vertical stride (1..8).
COL_STRIDE, 1, horizontal stride (1..8).
AW, 5, column address width; must be >= $clog2(INPUT_X_DIM).
YW, 5, row index width; must be >= $clog2(INPUT_Y_DIM+1).

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous abort; returns the block to the start of a frame
in_valid  in  1  input pixel valid
in_ready  out  1  pixel accepted when in_valid && in_ready
out_ready  in  1  downstream window consumer ready
addr  out  AW  column address, shared by read and write (= col_ptr)
write_en  out  K+1  one-hot bank write enable
read_en  out  K+1  bank read enables
win_valid  out  1  a window is presented this cycle
win_row  out  YW  top row index of the presented window
win_col  out  AW  rightmost column of the presented window (= col_ptr)
row_is_complete  out  1  pulse: last pixel of an input row accepted
frame_done  out  1  pulse: last drain column advanced

Behaviour:
- State registers: state {FILL, STREAM, DRAIN}, col_ptr, row_ptr (0..K), y_ptr (0..Y), col_phase, row_phase.
- On rst or flush, all state registers clear to 0 and state goes to FILL. Derived outputs then are: in_ready=1, win_valid=0, write_en=0, read_en=0, pulses=0.
- Window candidate: cand = (state!=FILL) && col_ptr>=K-1 && col_phase==0 && row_phase==0.
- in_ready = (state!=DRAIN) && (!cand || out_ready).
- accept = in_valid && in_ready.
- win_valid = cand && (state==DRAIN || in_valid). A window transfers when win_valid && out_ready.
- adv (column advance) = accept in FILL/STREAM; (!cand || out_ready) in DRAIN.
- write_en = onehot(row_ptr) gated by accept. It is never asserted in DRAIN.
- read_en = ~onehot(row_ptr) gated by adv && state!=FILL.
- On adv: col_ptr wraps X-1 to 0, otherwise increments. When col_ptr>=K-1, col_phase advances modulo COL_STRIDE; it clears at each row end.
- Row end (adv with col_ptr==X-1):
  - row_ptr wraps K to 0, otherwise increments.
  - y_ptr increments.
  - In STREAM/DRAIN, row_phase advances modulo ROW_STRIDE.
- FILL to STREAM at the end of row K-1, with row_phase=0.
- STREAM to DRAIN at the end of row Y-1.
- DRAIN to FILL at the end of the drain row. frame_done pulses (combinational) in that cycle and all state clears.
- win_row = y_ptr - K. win_col = col_ptr.
- Windows per frame = ceil((X-K+1)/COL_STRIDE) * ceil((Y-K+1)/ROW_STRIDE).
- row_is_complete = accept && col_ptr==X-1. It does not pulse for the drain row.
- Backpressure holds all state. addr, win_row and win_col stay stable while win_valid && !out_ready.
- flush takes priority over any simultaneous accept or adv.
- rst mid-frame or mid-drain abandons the frame; no frame_done is produced.

Optional Feature:
WIN_COUNT_EN: when defined, adds output port win_count [15:0].
- An internal counter increments on each window transfer and clears on rst/flush.
- At frame_done, the counter is copied into win_count and then cleared.
- win_count holds until the next frame_done; reset value 0.
- When not defined, neither the port nor the logic exists.

Test Plan:
- X=6, Y=5, K=3, strides 1, in_valid=1, out_ready=1, 30 pixels -> 12 windows (win_row 0..2 × win_col 2..5); frame_done 6 cycles after the last pixel; in_ready=0 during drain.
- Same dims, ROW_STRIDE=COL_STRIDE=2 -> 4 windows at (row,col) = (0,2),(0,4),(2,2),(2,4); WIN_COUNT_EN build gives win_count=4 after frame_done.
- Stride 1, out_ready=0 for 3 cycles at the first window -> in_ready=0, win_valid=1, addr=2 held stable; resumes with no pixel lost; still 12 windows.
- write_en rotation -> accepted pixels in rows 0..4 write banks 0,1,2,3,0; read_en=~write_en (e.g. 4'b1110 during row 4) only from row 3 on.
- flush asserted mid-row 3 with col_ptr=4 -> next cycle state=FILL, addr=0, no frame_done; a following full frame yields 12 windows.
- rst asserted during drain -> all outputs at reset values immediately; no frame_done.
